// File: rtl/spi_master_packet_reader.sv
// spi_master_packet_reader
//   SPI mode-0 master that reads one 32-byte sensor packet from the MCU slave.
//   On `start` it waits for the slave's `done` (two-flop synchronized), raises
//   `load`, clocks in 256 bits MSB-first, checks byte 0 against HEADER, and
//   publishes both sensors' quaternion/gyro/flag fields on registered outputs.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 one-cycle read request, accepted only in IDLE
//   sck, sdo, sdi         SPI clock (idle low), data out (always 0), data in
//   load                  high for the whole transaction (SETUP..HOLD)
//   done                  slave data-ready, asynchronous
//   busy                  high whenever the FSM is not IDLE
//   pkt_valid/hdr_err/timeout_err   one-cycle result pulses
//   quat*/gyro*/flags*    unpacked packet fields, updated only on pkt_valid
//
// Handshake: a request is a single-cycle `start` seen while busy=0; it is
// dropped otherwise (never queued). Every accepted request ends in exactly one
// of pkt_valid, hdr_err or timeout_err, after which busy returns to 0.
module spi_master_packet_reader #(
  parameter int         CLK_DIV = 2,
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               sck,
  output logic               sdo,
  input  logic               sdi,
  output logic               load,
  input  logic               done,
  output logic               busy,
  output logic               pkt_valid,
  output logic               hdr_err,
  output logic               timeout_err,
  output logic signed [15:0] quat1_w,
  output logic signed [15:0] quat1_x,
  output logic signed [15:0] quat1_y,
  output logic signed [15:0] quat1_z,
  output logic signed [15:0] gyro1_x,
  output logic signed [15:0] gyro1_y,
  output logic signed [15:0] gyro1_z,
  output logic [7:0]         flags1,
  output logic signed [15:0] quat2_w,
  output logic signed [15:0] quat2_x,
  output logic signed [15:0] quat2_y,
  output logic signed [15:0] quat2_z,
  output logic signed [15:0] gyro2_x,
  output logic signed [15:0] gyro2_y,
  output logic signed [15:0] gyro2_z,
  output logic [7:0]         flags2
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DONE, S_SETUP, S_SHIFT, S_HOLD, S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic             done_meta_q, done_s_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             sck_q, sck_d;
  logic             load_q, load_d;
  logic [255:0]     sr_q, sr_d;
  // Bytes 1..30 of the last accepted packet; header and reserved byte are not kept.
  logic [239:0]     pkt_q, pkt_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             hdr_err_q, hdr_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             div_last;
  logic             unused_reserved;

  assign div_last        = (div_cnt_q == DIV_LAST);
  assign unused_reserved = ^sr_q[7:0];

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    sck_d         = sck_q;
    sr_d          = sr_q;
    pkt_d         = pkt_q;
    pkt_valid_d   = 1'b0;
    hdr_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        if (start) begin
          state_d   = S_WAIT_DONE;
          tmo_cnt_d = '0;
        end
      end
      S_WAIT_DONE: begin
        if (done_s_q) begin
          state_d   = S_SETUP;
          div_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          // Never passes TMO_LAST, so the count saturates instead of wrapping.
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d   = S_SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            // Sample on the clk edge that raises sck (mode 0 rising-edge sample).
            sck_d = 1'b1;
            sr_d  = {sr_q[254:0], sdi};
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == 8'd255) state_d = S_HOLD;
            else                     bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_last) begin
          // Result is registered on entry to RELEASE so it coincides with load=0.
          state_d = S_RELEASE;
          if (sr_q[255:248] == HEADER) begin
            pkt_d       = sr_q[247:8];
            pkt_valid_d = 1'b1;
          end else begin
            hdr_err_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    load_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      done_meta_q   <= 1'b0;
      done_s_q      <= 1'b0;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      sck_q         <= 1'b0;
      load_q        <= 1'b0;
      sr_q          <= '0;
      pkt_q         <= '0;
      pkt_valid_q   <= 1'b0;
      hdr_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_meta_q   <= done;
      done_s_q      <= done_meta_q;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      sck_q         <= sck_d;
      load_q        <= load_d;
      sr_q          <= sr_d;
      pkt_q         <= pkt_d;
      pkt_valid_q   <= pkt_valid_d;
      hdr_err_q     <= hdr_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sck         = sck_q;
  assign sdo         = 1'b0;
  assign load        = load_q;
  assign busy        = (state_q != S_IDLE);
  assign pkt_valid   = pkt_valid_q;
  assign hdr_err     = hdr_err_q;
  assign timeout_err = timeout_err_q;

  assign quat1_w = pkt_q[239:224];
  assign quat1_x = pkt_q[223:208];
  assign quat1_y = pkt_q[207:192];
  assign quat1_z = pkt_q[191:176];
  assign gyro1_x = pkt_q[175:160];
  assign gyro1_y = pkt_q[159:144];
  assign gyro1_z = pkt_q[143:128];
  assign flags1  = pkt_q[127:120];
  assign quat2_w = pkt_q[119:104];
  assign quat2_x = pkt_q[103:88];
  assign quat2_y = pkt_q[87:72];
  assign quat2_z = pkt_q[71:56];
  assign gyro2_x = pkt_q[55:40];
  assign gyro2_y = pkt_q[39:24];
  assign gyro2_z = pkt_q[23:8];
  assign flags2  = pkt_q[7:0];

endmodule

// File: tb/tb_spi_master_packet_reader.sv
// Testbench for spi_master_packet_reader. Three instances (CLK_DIV 2, 1, 4;
// TIMEOUT 16) share one behavioural SPI slave that follows the instance
// selected by `sel`. A scoreboard queue holds the expected result pulse and
// field contents for each accepted request; a monitor pops on every pulse.
module tb_spi_master_packet_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic done;
  logic sdi;
  logic [1:0] sel;

  logic [2:0] start_v, sck_v, sdo_v, load_v, busy_v, pv_v, he_v, te_v;
  logic [15:0] f16 [3][14];
  logic [7:0]  fl1 [3];
  logic [7:0]  fl2 [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [242:0] exp_q[$];
  logic [239:0] last_good [3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_master_packet_reader #(
      .CLK_DIV((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
      .HEADER (8'hAA),
      .TIMEOUT(16)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]),
      .sck(sck_v[g]), .sdo(sdo_v[g]), .sdi(sdi), .load(load_v[g]),
      .done(done), .busy(busy_v[g]), .pkt_valid(pv_v[g]),
      .hdr_err(he_v[g]), .timeout_err(te_v[g]),
      .quat1_w(f16[g][0]), .quat1_x(f16[g][1]), .quat1_y(f16[g][2]),
      .quat1_z(f16[g][3]), .gyro1_x(f16[g][4]), .gyro1_y(f16[g][5]),
      .gyro1_z(f16[g][6]), .flags1(fl1[g]),
      .quat2_w(f16[g][7]), .quat2_x(f16[g][8]), .quat2_y(f16[g][9]),
      .quat2_z(f16[g][10]), .gyro2_x(f16[g][11]), .gyro2_y(f16[g][12]),
      .gyro2_z(f16[g][13]), .flags2(fl2[g])
    );
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic logic [239:0] act_fields(input int i);
    return {f16[i][0], f16[i][1], f16[i][2], f16[i][3], f16[i][4], f16[i][5],
            f16[i][6], fl1[i], f16[i][7], f16[i][8], f16[i][9], f16[i][10],
            f16[i][11], f16[i][12], f16[i][13], fl2[i]};
  endfunction

  function automatic void check(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural SPI slave ----------------
  logic [255:0] tx_pkt = '0;
  int idx = 0, rise_cnt = 0, cyc = 0, last_rise = -1, per_min = 0, per_max = 0;
  wire sck_sel  = sck_v[sel];
  wire load_sel = load_v[sel];

  always @(posedge clk) cyc++;
  always @(posedge load_sel) begin
    idx = 0; rise_cnt = 0; last_rise = -1; per_min = 1000; per_max = 0;
  end
  always @(negedge sck_sel) if (load_sel && idx < 256) idx++;
  always @(posedge sck_sel) begin
    if (load_sel) begin
      rise_cnt++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
    end
  end
  assign sdi = (load_sel && idx < 256) ? tx_pkt[8'(255 - idx)] : 1'b0;

  // ---------------- scoreboard monitor ----------------
  logic sdo_bad = 1'b0;
  always @(negedge clk) begin
    logic [2:0]   ev;
    logic [242:0] e;
    if (rst_n) begin
      if (sdo_v != 3'b000) sdo_bad = 1'b1;
      ev = {te_v[sel], he_v[sel], pv_v[sel]};
      if (ev != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 256'(ev), 256'(0));
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 256'(ev), 256'(e[242:240]));
          check("fields", 256'(act_fields(sel)), 256'(e[239:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mid: bit0 extra start at bit 50, bit1 drop done at bit 50,
  //      bit2 start in the RELEASE cycle.
  task automatic run_pkt(input int inst, input logic [7:0] hdr,
                         input logic [239:0] flds, input int done_delay,
                         input int mid);
    int k;
    sel = 2'(inst);
    tx_pkt = {hdr, flds, 8'hC3};
    if (hdr == 8'hAA) begin
      exp_q.push_back({3'b001, flds});
      last_good[inst] = flds;
    end else begin
      exp_q.push_back({3'b010, last_good[inst]});
    end
    if (done_delay == 0) begin
      done = 1'b1;
      repeat (3) @(negedge clk);
    end
    @(negedge clk); start_v[inst] = 1'b1;
    @(negedge clk); start_v[inst] = 1'b0;
    if (done_delay > 0) begin
      repeat (done_delay) @(negedge clk);
      done = 1'b1;
    end
    if (mid[1:0] != 0) begin
      k = 0;
      while (!(load_sel && idx >= 50) && k < 5000) begin @(negedge clk); k++; end
      if (mid[0]) start_v[inst] = 1'b1;
      if (mid[1]) done = 1'b0;
      @(negedge clk); start_v[inst] = 1'b0;
    end
    k = 0;
    while (busy_v[inst] && k < 5000) begin
      if (mid[2] && pv_v[inst]) start_v[inst] = 1'b1;
      @(negedge clk); k++;
    end
    start_v[inst] = 1'b0;
    check("finished_in_budget", 256'(busy_v[inst]), 256'(0));
    check("sck_rises_256", 256'(rise_cnt), 256'(256));
    check("sck_period_min", 256'(per_min), 256'(2 * div_of(inst)));
    check("sck_period_max", 256'(per_max), 256'(2 * div_of(inst)));
    done = 1'b0;
    repeat (6) @(negedge clk);
    check("no_queued_start", 256'(busy_v[inst]), 256'(0));
  endtask

  task automatic run_timeout(input int inst);
    int bc, k;
    logic load_seen;
    sel = 2'(inst);
    done = 1'b0;
    exp_q.push_back({3'b100, last_good[inst]});
    @(negedge clk); start_v[inst] = 1'b1;
    @(negedge clk); start_v[inst] = 1'b0;
    bc = 0; k = 0; load_seen = 1'b0;
    while (busy_v[inst] && k < 200) begin
      bc++;
      if (load_v[inst]) load_seen = 1'b1;
      @(negedge clk); k++;
    end
    check("timeout_wait_cycles", 256'(bc), 256'(16));
    check("timeout_no_load", 256'(load_seen), 256'(0));
    check("timeout_busy_low", 256'(busy_v[inst]), 256'(0));
    repeat (4) @(negedge clk);
  endtask

  task automatic run_reset_mid(input logic [239:0] flds);
    int k;
    sel = 2'd0;
    tx_pkt = {8'hAA, flds, 8'hC3};
    done = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    k = 0;
    while (!(load_sel && idx >= 100) && k < 5000) begin @(negedge clk); k++; end
    check("reached_bit_100", 256'(idx), 256'(100));
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 256'({sck_v[0], load_v[0], busy_v[0], pv_v[0], he_v[0], te_v[0]}), 256'(0));
    check("rst_fields", 256'(act_fields(0)), 256'(0));
    exp_q.delete();
    for (int i = 0; i < 3; i++) last_good[i] = '0;
    done = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [239:0] PKT_A = {16'd4000, 16'd1000, 16'd2000, 16'd3000,
    16'd100, 16'd200, 16'd300, 8'h03, 16'd5000, 16'd1100, 16'd2200, 16'd3300,
    16'd400, 16'd500, 16'd600, 8'h03};
  localparam logic [239:0] PKT_B = {16'h1111, 16'h2222, 16'h3333, 16'h4444,
    16'h5555, 16'h6666, 16'h7777, 8'h03, 16'h8888, 16'h9999, 16'hAAAA,
    16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 8'h03};
  localparam logic [239:0] PKT_S1 = {16'h6000, 16'h0123, 16'hFEDC, 16'h8000,
    16'h0011, 16'hFFF0, 16'h7FFF, 8'h01, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00};
  localparam logic [239:0] PKT_C = {16'hFFFF, 16'h0001, 16'h8001, 16'h7FFE,
    16'h1234, 16'h5678, 16'h9ABC, 8'h02, 16'hDEF0, 16'h0F0F, 16'hF0F0,
    16'h00FF, 16'hFF00, 16'h3C3C, 16'hC3C3, 8'h03};
  localparam logic [239:0] PKT_D = {16'hCAFE, 16'hBEEF, 16'h0F1E, 16'hF00D,
    16'hA5A5, 16'h5A5A, 16'h8421, 8'h03, 16'h1248, 16'hEDCB, 16'h0000,
    16'hFFFF, 16'h7F00, 16'h00F7, 16'h1001, 8'h01};

  initial begin
    rst_n = 1'b0; done = 1'b0; start_v = '0; sel = 2'd0;
    for (int i = 0; i < 3; i++) last_good[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ctrl", 256'({sck_v[i], sdo_v[i], load_v[i], busy_v[i],
                               pv_v[i], he_v[i], te_v[i]}), 256'(0));
      check("reset_fields", 256'(act_fields(i)), 256'(0));
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_pkt(0, 8'hAA, PKT_A, 0, 0);        // full packet, both sensors valid
    run_pkt(0, 8'h55, PKT_B, 0, 0);        // bad header, outputs hold PKT_A
    run_timeout(0);                         // done never arrives
    run_pkt(0, 8'hAA, PKT_S1, 5, 2);       // late done, done dropped mid-shift
    run_reset_mid(PKT_C);                   // async abort at bit 100
    run_pkt(0, 8'hAA, PKT_C, 0, 0);        // clean packet after reset
    run_pkt(1, 8'hAA, PKT_A, 0, 5);        // CLK_DIV=1, extra starts ignored
    run_pkt(2, 8'hAA, PKT_D, 0, 1);        // CLK_DIV=4, extra start ignored

    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    check("sdo_always_zero", 256'(sdo_bad), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
